// File: rtl/exe_pkg.sv
// Shared opcode, instruction-field and state definitions for the execution sequencer.
package exe_pkg;

    typedef enum logic [1:0] {
        OP_LI   = 2'b00,
        OP_ADD  = 2'b01,
        OP_JUMP = 2'b10,
        OP_HALT = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 14;
    localparam int RD_MSB  = 13;
    localparam int RD_LSB  = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 10;
    localparam int RT_MSB  = 9;
    localparam int RT_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/instr_decode.sv
// Splits the 16-bit instruction register into its fields; imm doubles as the JUMP target.
module instr_decode
    import exe_pkg::*;
(
    input  logic [15:0] ir_i,
    output opcode_e     op_o,
    output logic [1:0]  rd_o,
    output logic [1:0]  rs_o,
    output logic [1:0]  rt_o,
    output logic [7:0]  imm_o
);

    assign op_o  = opcode_e'(ir_i[OP_MSB:OP_LSB]);
    assign rd_o  = ir_i[RD_MSB:RD_LSB];
    assign rs_o  = ir_i[RS_MSB:RS_LSB];
    assign rt_o  = ir_i[RT_MSB:RT_LSB];
    assign imm_o = ir_i[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/exe_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving an external memory,
// register file and shared 8-bit adder.
module exe_sequencer
    import exe_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [1:0]  rf_raddr_a,
    output logic [1:0]  rf_raddr_b,
    input  logic [7:0]  rf_rdata_a,
    input  logic [7:0]  rf_rdata_b,
    output logic        rf_we,
    output logic [1:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic [7:0]  alu_input_a,
    output logic [7:0]  alu_input_b,
    input  logic [7:0]  alu_out,
    output logic [7:0]  pc,
    output logic        halted
);

    state_e      state_q;
    logic [7:0]  pc_q;
    logic [15:0] ir_q;
    logic [7:0]  result_q;

    opcode_e     op;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [7:0]  imm;

    instr_decode u_instr_decode (
        .ir_i  (ir_q),
        .op_o  (op),
        .rd_o  (rd),
        .rs_o  (rs),
        .rt_o  (rt),
        .imm_o (imm)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            result_q <= 8'h00;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_data;
                        pc_q    <= alu_out;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: state_q <= ST_EXECUTE;
                ST_EXECUTE: begin
                    unique case (op)
                        OP_LI: begin
                            result_q <= imm;
                            state_q  <= ST_WRITEBACK;
                        end
                        OP_ADD: begin
                            result_q <= alu_out;
                            state_q  <= ST_WRITEBACK;
                        end
                        OP_JUMP: begin
                            pc_q    <= imm;
                            state_q <= ST_FETCH;
                        end
                        OP_HALT: state_q <= ST_HALT;
                    endcase
                end
                ST_WRITEBACK: state_q <= ST_FETCH;
                ST_HALT:      state_q <= ST_HALT;
                default:      state_q <= ST_IDLE;
            endcase
        end
    end

    // Read ports follow IR continuously so rf_rdata stays valid through EXECUTE.
    assign rf_raddr_a = rs;
    assign rf_raddr_b = rt;

    // Outputs are decoded from the registered state; an asserted reset also masks
    // them so nothing (in particular rf_we) escapes on the reset edge.
    // NOTE: every output gets a default first, so no path through the block can
    // infer a latch.
    always_comb begin
        imem_req    = 1'b0;
        alu_input_a = 8'h00;
        alu_input_b = 8'h00;
        rf_we       = 1'b0;
        rf_waddr    = 2'b00;
        rf_wdata    = 8'h00;
        halted      = 1'b0;
        if (reset) begin
            unique case (state_q)
                ST_FETCH: begin
                    imem_req    = 1'b1;
                    alu_input_a = pc_q;
                    alu_input_b = 8'h01;
                end
                ST_EXECUTE: begin
                    if (op == OP_ADD) begin
                        alu_input_a = rf_rdata_a;
                        alu_input_b = rf_rdata_b;
                    end
                end
                ST_WRITEBACK: begin
                    rf_we    = 1'b1;
                    rf_waddr = rd;
                    rf_wdata = result_q;
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc        = reset ? pc_q : RESET_PC;
    assign imem_addr = pc;

endmodule

// File: tb/tb_exe_sequencer.sv
// Randomized self-checking bench: an instruction-level model predicts fetch addresses,
// register writes, latencies and halting for the exe_sequencer.
module tb_exe_sequencer;

    localparam logic [7:0] RST_PC = 8'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [1:0]  rf_raddr_a;
    logic [1:0]  rf_raddr_b;
    logic [7:0]  rf_rdata_a;
    logic [7:0]  rf_rdata_b;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [7:0]  alu_input_a;
    logic [7:0]  alu_input_b;
    logic [7:0]  alu_out;
    logic [7:0]  pc;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    exe_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_rdata_a  (rf_rdata_a),
        .rf_rdata_b  (rf_rdata_b),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alu_input_a (alu_input_a),
        .alu_input_b (alu_input_b),
        .alu_out     (alu_out),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Environment: register file and the external adder.
    logic [7:0] rf [4] = '{default: 8'h00};
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    assign alu_out    = alu_input_a + alu_input_b;
    always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

    logic [15:0] mem [256];

    // Instruction-level reference state.
    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
        int         cyc;
    } wr_t;
    wr_t        wq[$];
    logic [7:0] m_pc;
    logic [7:0] m_regs [4] = '{default: 8'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk);
        reset     = 1'b0;
        run       = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        tick();
        tick();
        if (chk) begin
            check("rst_imem_req", imem_req, 0);
            check("rst_rf_we", rf_we, 0);
            check("rst_rf_waddr", rf_waddr, 0);
            check("rst_rf_wdata", rf_wdata, 0);
            check("rst_alu_a", alu_input_a, 0);
            check("rst_alu_b", alu_input_b, 0);
            check("rst_halted", halted, 0);
            check("rst_pc", pc, RST_PC);
        end
        reset = 1'b1;
        tick();
        if (chk) begin
            check("idle_no_req", imem_req, 0);
            check("idle_pc", pc, RST_PC);
        end
    endtask

    function automatic logic [15:0] rnd_instr();
        int          r;
        logic [15:0] w;
        r = $urandom_range(0, 15);
        w = 16'($urandom);
        w[15:14] = (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : (r < 14) ? 2'b10 : 2'b11;
        return w;
    endfunction

    // Runs from IDLE; delay < 0 picks a random ack wait per fetch.
    task automatic run_prog(input int budget, input int delay, input bit expect_halt);
        int          cyc = 0;
        int          ack_cyc = -1;
        int          lat_exp = 0;
        int          wait_left = 0;
        int          halt_cyc = -1;
        int          dec_cyc = -1;
        int          exe_cyc = -1;
        bit          in_fetch = 1'b0;
        bit          done = 1'b0;
        logic [7:0]  ea = 8'h00;
        logic [7:0]  eb = 8'h00;
        logic [15:0] ins;
        wr_t         w;
        wq.delete();
        m_pc = RST_PC;
        run  = 1'b1;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
            if (imem_req) begin
                if (!in_fetch) begin
                    in_fetch = 1'b1;
                    if (ack_cyc >= 0) check("fetch_latency", cyc - ack_cyc, lat_exp);
                    check("fetch_addr", imem_addr, m_pc);
                    check("halted_low", halted, 0);
                    wait_left = (delay < 0) ? $urandom_range(0, 3) : delay;
                end
                check("fetch_pc", pc, m_pc);
                check("fetch_addr_stable", imem_addr, m_pc);
                check("fetch_alu_a", alu_input_a, m_pc);
                check("fetch_alu_b", alu_input_b, 8'h01);
                if (wait_left > 0) begin
                    wait_left--;
                    imem_ack  = 1'b0;
                    imem_data = 16'($urandom);
                end else begin
                    ins       = mem[imem_addr];
                    imem_ack  = 1'b1;
                    imem_data = ins;
                    in_fetch  = 1'b0;
                    ack_cyc   = cyc;
                    dec_cyc   = cyc + 1;
                    exe_cyc   = cyc + 2;
                    ea        = 8'h00;
                    eb        = 8'h00;
                    lat_exp   = 4;
                    m_pc      = m_pc + 8'd1;
                    case (ins[15:14])
                        2'b00: wq.push_back('{ins[13:12], ins[7:0], cyc + 3});
                        2'b01: begin
                            ea = m_regs[ins[11:10]];
                            eb = m_regs[ins[9:8]];
                            wq.push_back('{ins[13:12], 8'(ea + eb), cyc + 3});
                        end
                        2'b10: begin
                            m_pc    = ins[7:0];
                            lat_exp = 3;
                        end
                        default: halt_cyc = cyc + 3;
                    endcase
                end
            end else begin
                if (in_fetch) check("req_held", imem_req, 1);
                in_fetch  = 1'b0;
                imem_ack  = 1'($urandom_range(0, 1));
                imem_data = 16'($urandom);
            end
            if (cyc == dec_cyc) begin
                check("decode_alu_a", alu_input_a, 0);
                check("decode_alu_b", alu_input_b, 0);
            end
            if (cyc == exe_cyc) begin
                check("exec_alu_a", alu_input_a, ea);
                check("exec_alu_b", alu_input_b, eb);
            end
            if (rf_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_we", 1, 0);
                end else begin
                    w = wq.pop_front();
                    check("we_addr", rf_waddr, w.a);
                    check("we_data", rf_wdata, w.d);
                    check("we_cycle", cyc, w.cyc);
                    m_regs[w.a] = w.d;
                end
            end
            if (halt_cyc >= 0) begin
                if (cyc == halt_cyc) begin
                    check("halted_high", halted, 1);
                    check("halt_pc", pc, m_pc);
                end
                if (cyc > halt_cyc) check("halt_no_req", imem_req, 0);
                if (cyc == halt_cyc + 3) done = 1'b1;
            end
        end
        imem_ack = 1'b0;
        if (expect_halt) check("halt_reached", done, 1);
        if (done) check("writes_drained", wq.size(), 0);
    endtask

    initial begin
        bit seen;
        reset     = 1'b0;
        run       = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;

        // LI, modulo ADD, JUMP to 0xFF, pc wrap to 0x00, HALT; zero-wait acks.
        mem[8'h10] = 16'h1005;
        mem[8'h11] = 16'h10F0;
        mem[8'h12] = 16'h2020;
        mem[8'h13] = 16'h7600;
        mem[8'h14] = 16'h80FF;
        mem[8'hFF] = 16'h007E;
        mem[8'h00] = 16'hC000;
        do_reset(1'b1);
        run_prog(100, 0, 1'b1);
        check("rf_r3_sum", rf[3], 8'h10);
        check("rf_r0_li", rf[0], 8'h7E);

        // JUMP at 0x10 to 0x40 then HALT, with a 3-cycle ack delay.
        mem[8'h10] = 16'h8040;
        mem[8'h40] = 16'hC000;
        do_reset(1'b1);
        run_prog(100, 3, 1'b1);

        // Reset while an ADD sits in WRITEBACK must suppress the write.
        mem[8'h10] = 16'h4600;
        do_reset(1'b0);
        run  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            imem_ack  = imem_req;
            imem_data = mem[imem_addr];
            seen      = rf_we;
        end
        check("wb_seen", seen, 1);
        reset    = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("rstwb_we", rf_we, 0);
        check("rstwb_pc", pc, RST_PC);
        check("rstwb_alu_a", alu_input_a, 0);
        tick();
        run   = 1'b0;
        reset = 1'b1;
        tick();
        check("rstwb_idle", imem_req, 0);
        check("rstwb_pc_after", pc, RST_PC);
        check("rstwb_no_write", rf[0], m_regs[0]);

        // Random programs with random ack delays and ignored stray acks.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++) mem[i] = rnd_instr();
            do_reset(1'b0);
            run_prog(400, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_sequencer.md
EXE_SEQUENCER -- requirements
Module: exe_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-004 run  in  1  start enable; sampled in IDLE only.
REQ-005 imem_req  out  1  instruction fetch request.
REQ-006 imem_addr  out  8  fetch address (= pc).
REQ-007 imem_ack  in  1  fetch complete; imem_data valid this cycle.
REQ-008 imem_data  in  16  instruction word.
REQ-009 rf_raddr_a / rf_raddr_b  out  2 each  register-file read addresses (rs, rt).
REQ-010 rf_rdata_a / rf_rdata_b  in  8 each  combinational read data.
REQ-011 rf_we  out  1; rf_waddr  out  2; rf_wdata  out  8: register-file write port.
REQ-012 alu_input_a / alu_input_b  out  8 each  operands to the shared 8-bit adder.
REQ-013 alu_out  in  8  adder sum, combinational, carry already discarded.
REQ-014 pc  out  8  current program counter; halted  out  1  HALT state indicator.

Function
REQ-015 Instruction format: op=[15:14]; 00 LI (rd=[13:12], imm=[7:0]); 01 ADD (rd=[13:12], rs=[11:10], rt=[9:8]); 10 JUMP (target=[7:0]); 11 HALT.
REQ-016 States SHALL be IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-017 IDLE: all strobes low; run=1 -> FETCH next cycle.
REQ-018 FETCH: imem_req=1, imem_addr=pc, alu_input_a=pc, alu_input_b=8'h01; held until imem_ack=1; on ack latch imem_data into IR, pc<=alu_out, -> DECODE.
REQ-019 imem_ack outside FETCH SHALL be ignored; imem_req SHALL drop the cycle after ack.
REQ-020 DECODE: rf_raddr_a=rs, rf_raddr_b=rt from IR; -> EXECUTE (one cycle).
REQ-021 EXECUTE, ADD: alu_input_a=rf_rdata_a, alu_input_b=rf_rdata_b; result<=alu_out; -> WRITEBACK.
REQ-022 EXECUTE, LI: result<=imm; -> WRITEBACK.
REQ-023 EXECUTE, JUMP: pc<=target (overrides incremented pc); -> FETCH.
REQ-024 EXECUTE, HALT: -> HALT; pc holds address following the HALT.
REQ-025 WRITEBACK: rf_we=1 exactly one cycle, rf_waddr=rd, rf_wdata=result; -> FETCH.
REQ-026 HALT: halted=1, all strobes low; exit only by reset.
REQ-027 Arithmetic modulo 256: pc 8'hFF increments to 8'h00; ADD 8'hF0+8'h20 writes 8'h10.
REQ-028 In states other than FETCH and EXECUTE-ADD, alu_input_a/b SHALL be 8'h00.
REQ-029 Latency with zero-wait ack: ADD/LI 4 cycles FETCH->FETCH, JUMP 3 cycles.
REQ-030 rf_we SHALL never assert outside WRITEBACK; JUMP and HALT never write.

Reset
REQ-031 reset=0 at any edge, including mid-fetch or during WRITEBACK: state<=IDLE, pc<=RESET_PC, IR<=16'h0000, result<=8'h00, no write issued that cycle.
REQ-032 Outputs during/after reset: imem_req=0, rf_we=0, rf_waddr=0, rf_wdata=0, alu inputs=0, halted=0, pc=RESET_PC.

Structure
REQ-033 Opcode constants, field positions and state encodings SHALL reside in shared package exe_pkg.
REQ-034 A single sub-module instr_decode SHALL split IR into op, rd, rs, rt, imm/target combinationally.
REQ-035 The adder SHALL remain external; exe_sequencer only time-multiplexes its operands.

Verification
REQ-036 Reset, run=1, imem returns LI r1,8'h05 with ack same cycle -> WRITEBACK rf_we=1, waddr=1, wdata=8'h05, 4 cycles after FETCH entry.
REQ-037 r1=8'hF0, r2=8'h20, ADD r3,r1,r2 -> rf_wdata=8'h10 to r3; pc advanced by 1.
REQ-038 JUMP 8'h40 at pc 8'h10 -> next imem_addr=8'h40, no rf_we pulse.
REQ-039 imem_ack delayed 3 cycles -> imem_req held 4 cycles, imem_addr stable, pc unchanged until ack.
REQ-040 pc=8'hFF fetch LI -> pc becomes 8'h00; HALT at 8'h00 -> halted=1, no further imem_req.
REQ-041 reset=0 asserted during WRITEBACK of ADD -> rf_we=0 that cycle, state IDLE, pc=RESET_PC.
